anton_neopixel_frame_loader: RTL

ANTON_NEOPIXEL_FRAME_LOADER -- requirements
Module: anton_neopixel_frame_loader

---
 rtl/anton_neopixel_frame_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/anton_neopixel_frame_loader.sv
// Streams pixel bytes into a NeoPixel controller's buffer over a simple write bus, then
// programs the frame length and control register and pulses a one-cycle frame sync.
module anton_neopixel_frame_loader #(
  parameter int          BUFFER_END = 1023,
  parameter logic [13:0] MAX_ADDR_L = 14'h2000,
  parameter logic [13:0] MAX_ADDR_H = 14'h2001,
  parameter logic [13:0] CTRL_ADDR  = 14'h2002,
  parameter logic [7:0]  CTRL_VALUE = 8'h05
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  input  logic        inLast,
  output logic        inReady,
  input  logic        neoState,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataOut,
  output logic        busWrite,
  output logic        busRead,
  output logic        syncStart,
  output logic        frameDone,
  output logic        overflow,
  output logic        busy
);

  localparam int CNT_W = $clog2(BUFFER_END + 1) + 1;
  localparam int IDX_W = 13;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUFFER_END);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUFFER_END);

  typedef enum logic [2:0] {RECV, MAX_L, MAX_H, CTRL, SYNC} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [IDX_W-1:0] lastIdx, lastIdxNext;
  logic             overflowNext;
  logic             writeNext;
  logic [13:0]      addrNext;
  logic [7:0]       dataNext;
  logic             syncNext;
  logic [1:0]       neoSync;
  logic             accept;

  // neoState comes from the streaming clock domain; only neoSync[1] is safe to use.
  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) neoSync <= '0;
    else          neoSync <= {neoSync[0], neoState};
  end

  // Downstream busy only blocks the start of a frame, never a frame in progress.
  assign inReady   = (state == RECV) && ((cnt != '0) || !neoSync[1]);
  assign accept    = inValid && inReady;
  assign busRead   = 1'b0;
  assign frameDone = syncStart;
  assign busy      = (state != RECV) || (cnt != '0);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    lastIdxNext  = lastIdx;
    overflowNext = overflow;
    writeNext    = 1'b0;
    addrNext     = '0;
    dataNext     = '0;
    syncNext     = 1'b0;
    unique case (state)
      RECV: begin
        if (accept) begin
          if (cnt == '0) overflowNext = 1'b0;
          if (cnt <= CNT_LAST) begin
            writeNext = 1'b1;
            addrNext  = 14'(cnt);
            dataNext  = inData;
            cntNext   = cnt + 1'b1;
          end else begin
            overflowNext = 1'b1;
          end
          if (inLast) begin
            lastIdxNext = (cnt > CNT_LAST) ? IDX_LAST : IDX_W'(cnt);
            stateNext   = MAX_L;
          end
        end
      end
      MAX_L: begin
        writeNext = 1'b1;
        addrNext  = MAX_ADDR_L;
        dataNext  = lastIdx[7:0];
        stateNext = MAX_H;
      end
      MAX_H: begin
        writeNext = 1'b1;
        addrNext  = MAX_ADDR_H;
        dataNext  = {3'b000, lastIdx[12:8]};
        stateNext = CTRL;
      end
      CTRL: begin
        writeNext = 1'b1;
        addrNext  = CTRL_ADDR;
        dataNext  = CTRL_VALUE;
        stateNext = SYNC;
      end
      SYNC: begin
        syncNext  = 1'b1;
        cntNext   = '0;
        stateNext = RECV;
      end
      default: stateNext = RECV;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      state      <= RECV;
      cnt        <= '0;
      lastIdx    <= '0;
      overflow   <= 1'b0;
      busWrite   <= 1'b0;
      busAddr    <= '0;
      busDataOut <= '0;
      syncStart  <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      lastIdx    <= lastIdxNext;
      overflow   <= overflowNext;
      busWrite   <= writeNext;
      busAddr    <= addrNext;
      busDataOut <= dataNext;
      syncStart  <= syncNext;
    end
  end

endmodule
